// File: rtl/io_port_ctrl.sv
// CPU I/O unit: strobed input ports with pending flags, write-back source mux,
// and a first-word-fall-through output FIFO drained over a valid/ready handshake.
module io_port_ctrl #(
  parameter int W      = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [W-1:0]        F,
  input  logic [SEL_W-1:0]    rs,
  input  logic [NUM_IN*W-1:0] in_data,
  input  logic [NUM_IN-1:0]   in_stb,
  input  logic                rd_ack,
  output logic [W-1:0]        W_Data,
  output logic [NUM_IN-1:0]   in_pending,
  input  logic                wr_en,
  input  logic [W-1:0]        R_Data_B,
  output logic [W-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_full,
  output logic [CNT_W-1:0]    out_count,
  output logic                ovf_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]      in_reg_q [NUM_IN];
  logic [W-1:0]      in_reg_d [NUM_IN];
  logic [NUM_IN-1:0] pending_q, pending_d;

  logic [W-1:0]      mem_q [DEPTH];
  logic [W-1:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              pop;
  logic              push;

  // Selector values above NUM_IN match no port and leave W_Data at zero.
  always_comb begin
    W_Data = '0;
    if (rs == '0) begin
      W_Data = F;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (rs == SEL_W'(k + 1)) W_Data = in_reg_q[k];
      end
    end
  end

  // The strobe is applied after the ack so a same-cycle capture keeps pending set.
  always_comb begin
    in_reg_d  = in_reg_q;
    pending_d = pending_q;
    for (int k = 0; k < NUM_IN; k++) begin
      if (rd_ack && (rs == SEL_W'(k + 1))) pending_d[k] = 1'b0;
      if (in_stb[k]) begin
        in_reg_d[k]  = in_data[k*W +: W];
        pending_d[k] = 1'b1;
      end
    end
  end

  assign in_pending = pending_q;
  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_full   = (count_q == CNT_W'(DEPTH));
  assign out_count  = count_q;
  assign ovf_err    = ovf_q;

  assign pop  = out_valid & out_ready;
  assign push = wr_en & (~out_full | pop);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = R_Data_B;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (wr_en && out_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int k = 0; k < NUM_IN; k++) in_reg_q[k] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pending_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_IN; k++) in_reg_q[k] <= in_reg_d[k];
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      pending_q <= pending_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl with a queue-based reference model checked every cycle.
module tb_io_port_ctrl;

  localparam int W      = 32;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 3;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic [W-1:0]        F;
  logic [SEL_W-1:0]    rs;
  logic [NUM_IN*W-1:0] in_data;
  logic [NUM_IN-1:0]   in_stb;
  logic                rd_ack;
  logic [W-1:0]        W_Data;
  logic [NUM_IN-1:0]   in_pending;
  logic                wr_en;
  logic [W-1:0]        R_Data_B;
  logic [W-1:0]        out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_full;
  logic [CNT_W-1:0]    out_count;
  logic                ovf_err;

  int checks = 0;
  int fails  = 0;

  io_port_ctrl #(.W(W), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .F(F), .rs(rs), .in_data(in_data), .in_stb(in_stb),
    .rd_ack(rd_ack), .W_Data(W_Data), .in_pending(in_pending), .wr_en(wr_en),
    .R_Data_B(R_Data_B), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_full(out_full), .out_count(out_count), .ovf_err(ovf_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: port values, pending bits and the FIFO contents as a plain queue.
  logic [W-1:0]      mVal [NUM_IN];
  logic [NUM_IN-1:0] mPend;
  logic [W-1:0]      mQ [$];
  logic              mOvf;
  bit                modelReady = 0;

  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int k = 0; k < NUM_IN; k++) mVal[k] = '0;
      mPend = '0;
      mQ.delete();
      mOvf = 1'b0;
      modelReady = 1;
    end else if (modelReady) begin
      bit doPop;
      bit doPush;
      doPop  = (mQ.size() != 0) && out_ready;
      doPush = wr_en && ((mQ.size() < DEPTH) || doPop);
      if (wr_en && (mQ.size() == DEPTH) && !doPop) mOvf = 1'b1;
      if (doPop) void'(mQ.pop_front());
      if (doPush) mQ.push_back(R_Data_B);
      for (int k = 0; k < NUM_IN; k++) begin
        if (rd_ack && (int'(rs) == k + 1)) mPend[k] = 1'b0;
        if (in_stb[k]) begin
          mPend[k] = 1'b1;
          mVal[k]  = in_data[k*W +: W];
        end
      end
    end
  end

  function automatic logic [W-1:0] modelWData();
    if (rs == 0) return F;
    if (int'(rs) <= NUM_IN) return mVal[int'(rs) - 1];
    return '0;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (modelReady) begin
      checkOutput("cyc_wdata",   W_Data, modelWData());
      checkOutput("cyc_pending", W'(in_pending), W'(mPend));
      checkOutput("cyc_valid",   W'(out_valid), W'(mQ.size() != 0));
      checkOutput("cyc_full",    W'(out_full), W'(mQ.size() == DEPTH));
      checkOutput("cyc_count",   W'(out_count), W'(mQ.size()));
      checkOutput("cyc_ovf",     W'(ovf_err), W'(mOvf));
      if (mQ.size() != 0) checkOutput("cyc_head", out_data, mQ[0]);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus(input logic [NUM_IN-1:0] stb, input logic ack,
                               input logic [SEL_W-1:0] sel, input logic we,
                               input logic [W-1:0] wdata, input logic rdy);
    in_stb    = stb;
    rd_ack    = ack;
    rs        = sel;
    wr_en     = we;
    R_Data_B  = wdata;
    out_ready = rdy;
    tick();
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N     = 1'b0;
    F         = 32'h0000_1234;
    rs        = '0;
    in_data   = {32'h0404_0004, 32'hA5A5_0002, 32'h0202_0001, 32'h0101_0000};
    in_stb    = '1;
    rd_ack    = 1'b0;
    wr_en     = 1'b1;
    R_Data_B  = 32'hDEAD_BEEF;
    out_ready = 1'b0;

    // 1: reset dominates active strobes and pushes
    tick();
    RST_N = 1'b1;
    in_stb = '0;
    wr_en  = 1'b0;
    #1;
    checkOutput("rst_pending", W'(in_pending), 32'h0);
    checkOutput("rst_count",   W'(out_count), 32'h0);
    checkOutput("rst_valid",   W'(out_valid), 32'h0);
    checkOutput("rst_full",    W'(out_full), 32'h0);
    checkOutput("rst_ovf",     W'(ovf_err), 32'h0);
    checkOutput("rst_outdata", out_data, 32'h0);
    checkOutput("rst_wdata_f", W_Data, 32'h0000_1234);

    // 2: capture port 2, read it back, acknowledge, source selection
    applyStimulus(4'b0100, 1'b0, 3'd0, 1'b0, '0, 1'b0);
    in_stb = '0;
    rs = 3'd3;
    #1;
    checkOutput("cap_pending", W'(in_pending), 32'h4);
    checkOutput("cap_wdata",   W_Data, 32'hA5A5_0002);
    applyStimulus('0, 1'b1, 3'd3, 1'b0, '0, 1'b0);
    rd_ack = 1'b0;
    F = 32'd7;
    rs = 3'd0;
    #1;
    checkOutput("ack_pending", W'(in_pending), 32'h0);
    checkOutput("wdata_f7",    W_Data, 32'd7);
    rs = 3'd6;
    #1;
    checkOutput("wdata_oob",   W_Data, 32'h0);

    // rd_ack with rs=0 or rs>NUM_IN leaves pending flags alone
    applyStimulus(4'b0010, 1'b0, 3'd0, 1'b0, '0, 1'b0);
    applyStimulus('0, 1'b1, 3'd0, 1'b0, '0, 1'b0);
    applyStimulus('0, 1'b1, 3'd7, 1'b0, '0, 1'b0);
    applyStimulus('0, 1'b1, 3'd5, 1'b0, '0, 1'b0);
    rd_ack = 1'b0;
    #1;
    checkOutput("ign_ack_pending", W'(in_pending), 32'h2);

    // 3: same-cycle capture and ack on port 0, then overwrite while pending
    in_data[31:0] = 32'hBEEF_0001;
    applyStimulus(4'b0001, 1'b1, 3'd1, 1'b0, '0, 1'b0);
    rd_ack = 1'b0;
    in_stb = '0;
    #1;
    checkOutput("race_pending", W'(in_pending), 32'h3);
    checkOutput("race_wdata",   W_Data, 32'hBEEF_0001);
    in_data[31:0] = 32'hCAFE_0001;
    applyStimulus(4'b0001, 1'b0, 3'd1, 1'b0, '0, 1'b0);
    in_stb = '0;
    #1;
    checkOutput("ovw_wdata", W_Data, 32'hCAFE_0001);

    // 4: fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) applyStimulus('0, 1'b0, 3'd0, 1'b1, W'(i), 1'b0);
    #1;
    checkOutput("fill_full",  W'(out_full), 32'h1);
    checkOutput("fill_count", W'(out_count), 32'h4);
    applyStimulus('0, 1'b0, 3'd0, 1'b1, 32'd5, 1'b0);
    wr_en = 1'b0;
    #1;
    checkOutput("ovf_set",   W'(ovf_err), 32'h1);
    checkOutput("ovf_count", W'(out_count), 32'h4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checkOutput("drain_data", out_data, W'(i));
      tick();
    end
    #1;
    checkOutput("drain_valid", W'(out_valid), 32'h0);
    checkOutput("drain_ovf_sticky", W'(ovf_err), 32'h1);
    applyStimulus('0, 1'b0, 3'd0, 1'b0, '0, 1'b1);

    // 5: offset the pointers, fill across the wrap, push and pop together while full
    out_ready = 1'b0;
    doReset();
    applyStimulus('0, 1'b0, 3'd0, 1'b1, 32'd21, 1'b0);
    applyStimulus('0, 1'b0, 3'd0, 1'b1, 32'd22, 1'b0);
    applyStimulus('0, 1'b0, 3'd0, 1'b0, '0, 1'b1);
    applyStimulus('0, 1'b0, 3'd0, 1'b0, '0, 1'b1);
    for (int i = 11; i <= 14; i++) applyStimulus('0, 1'b0, 3'd0, 1'b1, W'(i), 1'b0);
    #1;
    checkOutput("wrap_full", W'(out_full), 32'h1);
    checkOutput("wrap_head", out_data, 32'd11);
    applyStimulus('0, 1'b0, 3'd0, 1'b1, 32'd9, 1'b1);
    wr_en = 1'b0;
    #1;
    checkOutput("pp_count", W'(out_count), 32'h4);
    checkOutput("pp_ovf",   W'(ovf_err), 32'h0);
    begin
      logic [W-1:0] expOrder [4];
      expOrder = '{32'd12, 32'd13, 32'd14, 32'd9};
      for (int i = 0; i < 4; i++) begin
        #1;
        checkOutput("pp_drain", out_data, expOrder[i]);
        tick();
      end
    end
    #1;
    checkOutput("pp_empty", W'(out_valid), 32'h0);
    out_ready = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
